// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and encodings for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_WR     = 3'd4,
    ST_RSP    = 3'd5
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int MEM_WE = 0;

  // Illegal size 2'b11 is treated as 4 bytes; it is rejected separately.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_lane_align.sv
// ============================================================================
// Module   : mem_lane_align
// Brief    : Store-lane merge and load-lane extract/extend, purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shift;

  // Aligned halves have addr[0]=0, so a byte-granular shift serves both sizes.
  assign w_shift = i_word >> {i_addr_lo, 3'b000};

  always_comb begin
    o_merged = i_old;
    case (i_size)
      SIZE_B: begin
        case (i_addr_lo)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else              o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

  always_comb begin
    case (i_size)
      SIZE_B:  o_rdata = i_unsigned ? {24'd0, w_shift[7:0]}
                                    : {{24{w_shift[7]}}, w_shift[7:0]};
      SIZE_H:  o_rdata = i_unsigned ? {16'd0, w_shift[15:0]}
                                    : {{16{w_shift[15]}}, w_shift[15:0]};
      default: o_rdata = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin fetch/data sequencer for a single-port word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 1024
)
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_sel;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;

  logic        w_pick_d;
  logic        w_we;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [32:0] w_end;
  logic        w_err;
  state_t      w_next;
  logic [31:0] w_merged;
  logic [31:0] w_load;
  logic        w_rsp;
  logic        w_mem_we;
  logic        w_mem_act;

  // Data wins only when fetch is idle or fetch was granted last.
  assign w_pick_d = d_req & (~if_req | (r_last_grant == PORT_IF));
  assign w_we     = w_pick_d & d_we;
  assign w_size   = w_pick_d ? d_size : SIZE_W;
  assign w_addr   = w_pick_d ? d_addr : if_addr;
  assign w_end    = {1'b0, w_addr} + {30'd0, size_bytes(w_size)};

  assign w_err = (w_size == 2'b11)
               | ((w_size == SIZE_H) & w_addr[0])
               | ((w_size == SIZE_W) & (|w_addr[1:0]))
               | (w_end > 33'(MEM_BYTES));

  always_comb begin
    w_next = ST_RMW_RD;
    if (w_err)                 w_next = ST_RSP;
    else if (!w_we)            w_next = ST_RD;
    else if (w_size == SIZE_W) w_next = ST_WR;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_D;
      r_sel        <= PORT_IF;
      r_we         <= 1'b0;
      r_size       <= SIZE_B;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (if_req | d_req) begin
            r_sel        <= w_pick_d;
            r_last_grant <= w_pick_d;
            r_we         <= w_we;
            r_size       <= w_size;
            r_unsigned   <= w_pick_d & d_unsigned;
            r_addr       <= w_addr;
            r_wdata      <= d_wdata;
            r_err        <= w_err;
            r_state      <= w_next;
          end
        end
        ST_RD:     r_state <= ST_RSP;
        ST_RMW_RD: r_state <= ST_RMW_WR;
        ST_RMW_WR: r_state <= ST_RSP;
        ST_WR:     r_state <= ST_RSP;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  mem_lane_align u_align (
    .i_old      (mem_data_out),
    .i_wdata    (r_wdata),
    .i_word     (mem_data_out),
    .i_addr_lo  (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_merged   (w_merged),
    .o_rdata    (w_load)
  );

  // Everything below decodes from r_state, so async reset silences it at once.
  assign w_rsp     = (r_state == ST_RSP);
  assign w_mem_we  = (r_state == ST_RMW_WR) | (r_state == ST_WR);
  assign w_mem_act = w_mem_we | (r_state == ST_RD) | (r_state == ST_RMW_RD);

  assign busy      = (r_state != ST_IDLE);
  assign if_rvalid = w_rsp & (r_sel == PORT_IF);
  assign if_err    = if_rvalid & r_err;
  assign if_rdata  = (if_rvalid & ~r_err) ? mem_data_out : '0;
  assign d_rvalid  = w_rsp & (r_sel == PORT_D);
  assign d_err     = d_rvalid & r_err;
  assign d_rdata   = (d_rvalid & ~r_err & ~r_we) ? w_load : '0;

  assign mem_address = w_mem_act ? {r_addr[31:2], 2'b00} : '0;

  always_comb begin
    mem_read_write         = '0;
    mem_read_write[MEM_WE] = w_mem_we;
  end

  always_comb begin
    case (r_state)
      ST_RMW_WR: mem_data_in = w_merged;
      ST_WR:     mem_data_in = r_wdata;
      default:   mem_data_in = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter with a synchronous word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int MEM_BYTES = 1024;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_unsigned = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_address, mem_read_write, mem_data_in;
  logic [31:0] mem_data_out;
  logic        busy;

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_read_write(mem_read_write), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
  );

  // Memory model: registered read, write of the full word when bit0 is set.
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clock) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_read_write[0]) mem[mem_address[9:2]] <= mem_data_in;
    mem_data_out <= mem[mem_address[9:2]];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  int rd_cnt = 0, wr_cnt = 0, acc_cnt = 0;
  logic [31:0] last_wr = '0;

  typedef struct {
    string       name;
    logic        port;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (mem_read_write != 32'd0) begin
        wr_cnt++;
        last_wr = mem_data_in;
      end else if (mem_address != 32'd0) begin
        rd_cnt++;
      end
      if (mem_read_write != 32'd0 || mem_address != 32'd0) acc_cnt++;
    end
  end

  always @(negedge clock) begin
    if (reset_n && (if_rvalid || d_rvalid)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: if_rvalid=%0b d_rvalid=%0b at cycle %0d, expected none",
                 if_rvalid, d_rvalid, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".port"},  32'(d_rvalid), 32'(e.port));
        chk({e.name, ".both"},  32'(if_rvalid & d_rvalid), 32'd0);
        chk({e.name, ".rdata"}, d_rvalid ? d_rdata : if_rdata, e.rdata);
        chk({e.name, ".err"},   32'(d_rvalid ? d_err : if_err), 32'(e.err));
        chk({e.name, ".cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.name, ".quiet"}, e.port ? 32'(if_err | (|if_rdata)) : 32'(d_err | (|d_rdata)), 32'd0);
      end
    end
  end

  task automatic push(input string name, input logic port, input logic [31:0] rd,
                      input logic err, input int lat);
    exp_t e;
    e.name = name; e.port = port; e.rdata = rd; e.err = err; e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout: %0d responses outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(posedge clock); #1;
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clock); #1;
    pre_we = 1'b0;
  endtask

  task automatic d_op(input string name, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat);
    @(posedge clock); #1;
    d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    push(name, PORT_D, exp_rd, exp_err, lat);
    wait_drain(name);
    d_req = 1'b0;
  endtask

  task automatic f_op(input string name, input logic [31:0] addr,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat);
    @(posedge clock); #1;
    if_addr = addr; if_req = 1'b1;
    push(name, PORT_IF, exp_rd, exp_err, lat);
    wait_drain(name);
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, a0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset.outs", {26'd0, if_rvalid, if_err, d_rvalid, d_err, busy, 1'b0}, 32'd0);
    chk("reset.mem_rw", mem_read_write | mem_address | mem_data_in, 32'd0);
    reset_n = 1'b1;

    preload(8'h04, 32'h00500093);
    preload(8'h08, 32'h80FF7F01);
    preload(8'h10, 32'h11223344);
    preload(8'hFF, 32'h0BADCAFE);

    // Both ports held: fetch wins the first tie, then strict alternation.
    @(posedge clock); #1;
    if_addr = 32'h10; d_we = 1'b0; d_size = SIZE_W; d_unsigned = 1'b0; d_addr = 32'h20;
    if_req = 1'b1; d_req = 1'b1;
    push("tie0_F", PORT_IF, 32'h00500093, 1'b0, 2);
    push("tie1_D", PORT_D,  32'h80FF7F01, 1'b0, 5);
    push("tie2_F", PORT_IF, 32'h00500093, 1'b0, 8);
    push("tie3_D", PORT_D,  32'h80FF7F01, 1'b0, 11);
    repeat (11) @(posedge clock);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    wait_drain("tie");

    f_op("fetch",       32'h10, 32'h00500093, 1'b0, 2);
    d_op("lb_22",   1'b0, SIZE_B, 1'b0, 32'h22, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    d_op("lb_23",   1'b0, SIZE_B, 1'b0, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    d_op("lbu_23",  1'b0, SIZE_B, 1'b1, 32'h23, 32'h0, 32'h00000080, 1'b0, 2);
    d_op("lbu_20",  1'b0, SIZE_B, 1'b1, 32'h20, 32'h0, 32'h00000001, 1'b0, 2);
    d_op("lh_20",   1'b0, SIZE_H, 1'b0, 32'h20, 32'h0, 32'h00007F01, 1'b0, 2);
    d_op("lh_22",   1'b0, SIZE_H, 1'b0, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    d_op("lw_last", 1'b0, SIZE_W, 1'b0, 32'h3FC, 32'h0, 32'h0BADCAFE, 1'b0, 2);

    r0 = rd_cnt; w0 = wr_cnt;
    d_op("sh_42", 1'b1, SIZE_H, 1'b0, 32'h42, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    chk("sh_42.reads",  32'(rd_cnt - r0), 32'd1);
    chk("sh_42.writes", 32'(wr_cnt - w0), 32'd1);
    chk("sh_42.wdata",  last_wr, 32'hBEEF3344);
    chk("sh_42.mem",    mem[8'h10], 32'hBEEF3344);

    d_op("sb_41",   1'b1, SIZE_B, 1'b0, 32'h41, 32'h123456A5, 32'h0, 1'b0, 3);
    d_op("lw_40",   1'b0, SIZE_W, 1'b0, 32'h40, 32'h0, 32'hBEEFA544, 1'b0, 2);
    w0 = wr_cnt;
    d_op("sw_44",   1'b1, SIZE_W, 1'b0, 32'h44, 32'hCAFEF00D, 32'h0, 1'b0, 2);
    chk("sw_44.wdata", last_wr, 32'hCAFEF00D);
    chk("sw_44.writes", 32'(wr_cnt - w0), 32'd1);
    d_op("lhu_46",  1'b0, SIZE_H, 1'b1, 32'h46, 32'h0, 32'h0000CAFE, 1'b0, 2);

    a0 = acc_cnt;
    d_op("err_lw41",  1'b0, SIZE_W, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1);
    d_op("err_lh43",  1'b0, SIZE_H, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1);
    d_op("err_lw3fe", 1'b0, SIZE_W, 1'b0, 32'(MEM_BYTES - 2), 32'h0, 32'h0, 1'b1, 1);
    d_op("err_lw400", 1'b0, SIZE_W, 1'b0, 32'(MEM_BYTES), 32'h0, 32'h0, 1'b1, 1);
    d_op("err_sz3",   1'b0, 2'b11,  1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1);
    d_op("err_sw41",  1'b1, SIZE_W, 1'b0, 32'h41, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    f_op("err_f12",   32'h12, 32'h0, 1'b1, 1);
    chk("err.no_mem_access", 32'(acc_cnt - a0), 32'd0);

    // Reset lands while the read-modify-write is in its write cycle.
    preload(8'h12, 32'h55667788);
    w0 = wr_cnt;
    @(posedge clock); #1;
    d_we = 1'b1; d_size = SIZE_B; d_unsigned = 1'b0; d_addr = 32'h48; d_wdata = 32'hFF; d_req = 1'b1;
    @(posedge clock);
    @(posedge clock); #2;
    chk("rst.in_rmw_wr", mem_read_write, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.async_we",   mem_read_write, 32'd0);
    chk("rst.async_busy", 32'(busy), 32'd0);
    d_req = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    chk("rst.outs", {26'd0, if_rvalid, if_err, d_rvalid, d_err, busy, 1'b0}, 32'd0);
    chk("rst.rdata", if_rdata | d_rdata, 32'd0);
    chk("rst.mem_if", mem_address | mem_read_write | mem_data_in, 32'd0);
    repeat (6) @(posedge clock);
    #1;
    chk("rst.no_write", 32'(wr_cnt - w0), 32'd0);
    chk("rst.mem_word", mem[8'h12], 32'h55667788);
    chk("rst.sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
